// File: rtl/rf_pkg.sv
// Shared constants and types for the multiport integer register file.
// The optional same-cycle write bypass is enabled with RF_WRITE_BYPASS_EN.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 1;
  localparam int ZERO_REG  = 0;

  localparam int AW_DEF = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy flag per architectural register.
// Writes retire a producer, allocs install one; an alloc beats a same-cycle write.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NWR   = NWR_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    // Applied after the write clears so a new producer supersedes the retiring one.
    if (alloc_en) begin
      busy_d[alloc_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/rf_multiport.sv
// N-read / M-write integer register file with pending-write scoreboard.
// Define RF_WRITE_BYPASS_EN to forward same-cycle write data to the read ports.
module rf_multiport
  import rf_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  parameter  int NWR   = NWR_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NREGS-1:0]    busy_vec
);

  // x0 has no storage; it is supplied as a constant in the read view.
  logic [XLEN-1:0] regs_q  [1:NREGS-1];
  logic [XLEN-1:0] rd_view [NREGS];

  logic [AW-1:0]   rd_a;
  logic [XLEN-1:0] rd_d;
  logic            rd_b;

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy_vec   (busy_vec)
  );

  // Ports are scanned in ascending order so the highest-index port's update lands last.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
            regs_q[r] <= wr_data[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_comb begin
    rd_view[ZERO_REG] = '0;
    for (int r = 1; r < NREGS; r++) begin
      rd_view[r] = regs_q[r];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_a    = '0;
    rd_d    = '0;
    rd_b    = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      rd_a = rd_addr[i*AW +: AW];
      rd_d = rd_view[rd_a];
      rd_b = busy_vec[rd_a];
`ifdef RF_WRITE_BYPASS_EN
      // Forwarding is suppressed under reset so reads show the cleared file.
      if (!reset && (rd_a != AW'(ZERO_REG))) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_a)) begin
            rd_d = wr_data[j*XLEN +: XLEN];
            rd_b = 1'b0;
          end
        end
      end
`endif
      rd_data[i*XLEN +: XLEN] = rd_d;
      rd_busy[i]              = rd_b;
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport at XLEN=64, NREGS=16, NRD=3, NWR=2.
// Expected values are hand-computed, plus a small register model for the random-write sweep.
module tb_rf_multiport;

  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int NRD   = 3;
  localparam int NWR   = 2;
  localparam int AW    = 4;

  logic                clock;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic [NREGS-1:0]    busy_vec;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] ref_regs [NREGS];
  logic [XLEN-1:0] exp_q [$];

  rf_multiport #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .busy_vec   (busy_vec)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
    wr_en[p]                = 1'b1;
    wr_addr[p*AW +: AW]     = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic alloc(input int a);
    alloc_en   = 1'b1;
    alloc_addr = AW'(a);
  endtask

  task automatic idle();
    wr_en    = '0;
    alloc_en = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] rdp(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  initial begin : stim
    int base;
    int a0;
    int a1;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;

    reset      = 1'b1;
    rd_addr    = '0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
    set_rd(0, 5);
    set_rd(1, 0);
    set_rd(2, 3);
    #12;
    check("reset_rd_data", {128'd0, rdp(0)} == '0 ? rdp(0) : rdp(0), 64'h0);
    check("reset_rd_data_all", XLEN'(rd_data != '0), 64'h0);
    check("reset_busy_vec", XLEN'(busy_vec), 64'h0);
    check("reset_rd_busy", XLEN'(rd_busy), 64'h0);
    reset = 1'b0;
    step();

    // write and allocate x5, then pulse reset mid-cycle
    wr(0, 5, 64'hDEAD_BEEF);
    alloc(5);
    step();
    idle();
    check("x5_written", rdp(0), 64'hDEAD_BEEF);
    check("x5_busy_vec", XLEN'(busy_vec), 64'h0020);
    check("x5_rd_busy", XLEN'(rd_busy[0]), 64'h1);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_data", rdp(0), 64'h0);
    check("async_reset_busy", XLEN'(busy_vec), 64'h0);
    #1;
    reset = 1'b0;

    // x0 writes and allocs are ignored
    wr(0, 0, 64'h1234_5678);
    alloc(0);
    step();
    idle();
    check("x0_read", rdp(1), 64'h0);
    check("x0_busy_vec", XLEN'(busy_vec), 64'h0);

    // same-address write conflict: port 1 wins
    wr(0, 7, 64'h1);
    wr(1, 7, 64'h2);
    step();
    idle();
    set_rd(0, 7);
    #1;
    check("dual_write_x7", rdp(0), 64'h2);
    check("x7_not_busy", XLEN'(rd_busy[0]), 64'h0);

    // scoreboard: alloc, retire, alloc+write together
    alloc(3);
    #1;
    check("alloc_not_same_cycle", XLEN'(rd_busy[2]), 64'h0);
    step();
    idle();
    check("alloc_x3_busy", XLEN'(rd_busy[2]), 64'h1);
    check("alloc_x3_busy_vec", XLEN'(busy_vec), 64'h0008);
    wr(0, 3, 64'hAA);
    step();
    idle();
    check("write_x3_clears", XLEN'(rd_busy[2]), 64'h0);
    check("write_x3_data", rdp(2), 64'hAA);
    alloc(3);
    wr(1, 3, 64'hBB);
    step();
    idle();
    check("alloc_wins_busy", XLEN'(rd_busy[2]), 64'h1);
    check("alloc_wins_data", rdp(2), 64'hBB);
    alloc(3);
    step();
    idle();
    check("waw_stays_busy", XLEN'(busy_vec), 64'h0008);

    // bypass: x9 holds 0x1111 and is busy, then written with 0xCAFE
    wr(0, 9, 64'h1111);
    alloc(9);
    step();
    idle();
    set_rd(1, 9);
    #1;
    check("x9_old", rdp(1), 64'h1111);
    check("x9_busy", XLEN'(rd_busy[1]), 64'h1);
    wr(1, 9, 64'hCAFE);
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check("bypass_data", rdp(1), 64'hCAFE);
    check("bypass_busy", XLEN'(rd_busy[1]), 64'h0);
`else
    check("nobypass_data", rdp(1), 64'h1111);
    check("nobypass_busy", XLEN'(rd_busy[1]), 64'h1);
`endif
    check("bypass_other_port", rdp(0), 64'h2);
    step();
    idle();
    check("x9_next_data", rdp(1), 64'hCAFE);
    check("x9_next_busy", XLEN'(rd_busy[1]), 64'h0);
    check("busy_vec_after_x9", XLEN'(busy_vec), 64'h0008);

    // sweep: fill every register, then random dual writes and three distinct reads
    ref_regs[0] = '0;
    for (int a = 1; a < NREGS; a += 2) begin
      d0 = {$urandom, $urandom};
      wr(0, a, d0);
      ref_regs[a] = d0;
      if (a + 1 < NREGS) begin
        d1 = {$urandom, $urandom};
        wr(1, a + 1, d1);
        ref_regs[a+1] = d1;
      end
      step();
      idle();
    end
    check("sweep_busy_clear", XLEN'(busy_vec), 64'h0);
    for (int it = 0; it < 12; it++) begin
      a0 = $urandom_range(1, NREGS - 1);
      a1 = (it % 4 == 0) ? a0 : $urandom_range(0, NREGS - 1);
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      wr(0, a0, d0);
      wr(1, a1, d1);
      ref_regs[a0] = d0;
      if (a1 != 0) ref_regs[a1] = d1;
      step();
      idle();
      base = $urandom_range(0, NREGS - 1);
      for (int p = 0; p < NRD; p++) begin
        set_rd(p, (base + 5 * p) % NREGS);
        exp_q.push_back(ref_regs[(base + 5 * p) % NREGS]);
      end
      #1;
      for (int p = 0; p < NRD; p++) begin
        check($sformatf("sweep_it%0d_port%0d", it, p), rdp(p), exp_q.pop_front());
      end
      check($sformatf("sweep_it%0d_busy", it), XLEN'(rd_busy), 64'h0);
    end

    // final reset with live data on every port
    set_rd(0, 1);
    set_rd(1, 8);
    set_rd(2, 15);
    #2;
    reset = 1'b1;
    #1;
    check("final_reset_data", XLEN'(rd_data != '0), 64'h0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
